// File: rtl/weight_loader_if.sv
// weight_loader_if: weight stream input and row-wide weight RAM write port
interface weight_loader_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int OUTPUT_NODES = 32
);
    logic [DATA_WIDTH-1:0]              s_data;
    logic                               s_valid;
    logic                               s_ready;
    logic                               wr_en;
    logic [7:0]                         wr_addr;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] wr_row;
    modport master (output s_data, s_valid, input s_ready, wr_en, wr_addr, wr_row);
    modport slave  (input s_data, s_valid, output s_ready, wr_en, wr_addr, wr_row);
endinterface

// File: rtl/weight_loader.sv
// weight_loader: packs a word stream into weight RAM rows; WEIGHT_LOADER_CHECKSUM_EN adds a running word checksum
module weight_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_NODES  = 100,
    parameter int OUTPUT_NODES = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    weight_loader_if.slave   bus,
    output logic             busy,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic             done,
    output logic [DATA_WIDTH-1:0] checksum
`else
    output logic             done
`endif
);
    localparam int CW = OUTPUT_NODES > 1 ? $clog2(OUTPUT_NODES) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OUTPUT_NODES - 1);
    localparam logic [7:0]    ROW_LAST = 8'(INPUT_NODES - 1);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    state_t state, state_d;
    logic [CW-1:0] col;
    logic [7:0] row;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] row_buf, buf_d;
    logic accept;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    // buf_d already holds the word accepted this cycle so the row write sees it
    always_comb begin
        accept = bus.s_valid && bus.s_ready;
        buf_d  = row_buf;
        if (accept) buf_d[(OUTPUT_NODES-1-int'(col))*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
        state_d = state == IDLE  ? (start ? LOAD : IDLE) :
                  state == LOAD  ? (accept && col == COL_LAST ? WRITE : LOAD) :
                  state == WRITE ? (row == ROW_LAST ? DONE : LOAD) : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bus.s_ready <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_row  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            col         <= '0;
            row         <= '0;
            row_buf     <= '0;
        end else begin
            bus.s_ready <= state_d == LOAD;
            bus.wr_en   <= state_d == WRITE;
            busy        <= state_d != IDLE;
            done        <= state_d == DONE;
            row_buf     <= buf_d;
            if (state_d == WRITE) begin
                bus.wr_addr <= row;
                bus.wr_row  <= buf_d;
            end
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (accept) col <= col == COL_LAST ? '0 : col + 1'b1;
            else if (state == WRITE && row != ROW_LAST) row <= row + 1'b1;
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)                    checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (accept)                 checksum <= checksum + bus.s_data;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized stream loads checked against a row-packing reference model
module tb_weight_loader;
    localparam int DW = 32, IN = 3, ON = 4, NW = IN * ON;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, busy, done;
    always #5 clk = ~clk;
    weight_loader_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(ON)) bus();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif
    weight_loader #(.DATA_WIDTH(DW), .INPUT_NODES(IN), .OUTPUT_NODES(ON)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus), .busy(busy),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done));

    typedef struct { logic [7:0] a; logic [DW*ON-1:0] d; int c; } wr_t;
    wr_t wr_q[$];
    logic [DW-1:0] acc_q[$];
    int acc_c[$];
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.s_valid && bus.s_ready) begin
            acc_q.push_back(bus.s_data);
            acc_c.push_back(cyc);
        end
        if (bus.wr_en) wr_q.push_back('{a: bus.wr_addr, d: bus.wr_row, c: cyc});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        wr_q.delete();
        acc_q.delete();
        acc_c.delete();
        done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w, input bit gap);
        bit ok = 0;
        int t = 0;
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = bus.s_ready;
            tick();
            t++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%h got no s_ready within 100 cycles", w);
        end
        if (gap) begin
            bus.s_valid = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input logic [DW-1:0] w[NW], input bit rnd_gap, input bit restart);
        clear_mon();
        pulse_start();
        for (int i = 0; i < NW; i++) begin
            send(w[i], rnd_gap ? 1'($urandom_range(0, 1)) : 1'b0);
            if (restart && i == 1) begin
                bus.s_valid = 1'b0;
                pulse_start();
                checks++;
                if (busy !== 1'b1 || bus.s_ready !== 1'b1 || acc_q.size() != 2) begin
                    errors++;
                    $display("FAIL restart_ignored busy=%b s_ready=%b accepted=%0d required busy=1 s_ready=1 accepted=2",
                             busy, bus.s_ready, acc_q.size());
                end
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic check_load(input string name, input logic [DW-1:0] w[NW], input bit exact);
        int t = 0;
        logic [DW-1:0] sum = '0;
        logic [DW*ON-1:0] exp_row;
        while (done_cnt == 0 && t < 200) begin
            tick();
            t++;
        end
        repeat (3) tick();
        checks++;
        if (acc_q.size() != NW) begin
            errors++;
            $display("FAIL %s accept_count got %0d required %0d", name, acc_q.size(), NW);
        end else
            for (int i = 0; i < NW; i++) begin
                checks++;
                if (acc_q[i] !== w[i]) begin
                    errors++;
                    $display("FAIL %s accept_word%0d got %h required %h", name, i, acc_q[i], w[i]);
                end
            end
        checks++;
        if (wr_q.size() != IN) begin
            errors++;
            $display("FAIL %s write_count got %0d required %0d", name, wr_q.size(), IN);
        end else begin
            for (int r = 0; r < IN; r++) begin
                exp_row = {w[ON*r], w[ON*r+1], w[ON*r+2], w[ON*r+3]};
                checks++;
                if (wr_q[r].a !== 8'(r) || wr_q[r].d !== exp_row) begin
                    errors++;
                    $display("FAIL %s row%0d got addr=%0d data=%h required addr=%0d data=%h",
                             name, r, wr_q[r].a, wr_q[r].d, r, exp_row);
                end
                if (acc_c.size() == NW) begin
                    checks++;
                    if (wr_q[r].c !== acc_c[ON*r+ON-1] + 1) begin
                        errors++;
                        $display("FAIL %s latency%0d got wr cycle %0d required %0d", name, r, wr_q[r].c, acc_c[ON*r+ON-1] + 1);
                    end
                end
                if (r > 0) begin
                    checks++;
                    if (exact ? (wr_q[r].c - wr_q[r-1].c != ON + 1) : (wr_q[r].c - wr_q[r-1].c < ON + 1)) begin
                        errors++;
                        $display("FAIL %s period%0d got %0d required %s%0d", name, r, wr_q[r].c - wr_q[r-1].c, exact ? "" : ">=", ON + 1);
                    end
                end
            end
            checks++;
            if (done_cyc !== wr_q[IN-1].c + 1) begin
                errors++;
                $display("FAIL %s done_timing got %0d required %0d", name, done_cyc, wr_q[IN-1].c + 1);
            end
            checks++;
            if (bus.wr_en !== 1'b0 || bus.wr_addr !== 8'(IN-1) || bus.wr_row !== wr_q[IN-1].d) begin
                errors++;
                $display("FAIL %s hold got wr_en=%b addr=%0d required wr_en=0 addr=%0d with last row held", name, bus.wr_en, bus.wr_addr, IN-1);
            end
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_count=%0d busy=%b s_ready=%b required 1 0 0", name, done_cnt, busy, bus.s_ready);
        end
        for (int i = 0; i < NW; i++) sum += w[i];
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
            errors++;
            $display("FAIL %s checksum got %h required %h", name, checksum, sum);
        end
`else
        if (sum === 'x) $display("unexpected unknown stream sum");
`endif
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_addr !== 8'd0 || bus.wr_row !== '0
            || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got s_ready=%b wr_en=%b wr_addr=%0d busy=%b done=%b wr_row=%h required all zero",
                     name, bus.s_ready, bus.wr_en, bus.wr_addr, busy, done, bus.wr_row);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== '0) begin
            errors++;
            $display("FAIL %s checksum got %h required 0", name, checksum);
        end
`endif
    endtask

    task automatic rand_words(output logic [DW-1:0] w[NW]);
        for (int i = 0; i < NW; i++) w[i] = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_zero("after_reset");
    endtask

    task automatic test_basic();
        logic [DW-1:0] w[NW];
        for (int i = 0; i < NW; i++) w[i] = 32'(i + 1);
        run_load(w, 1'b0, 1'b0);
        check_load("basic", w, 1'b1);
        checks++;
        if (wr_q.size() == 0 || wr_q[0].d !== 128'h00000001_00000002_00000003_00000004) begin
            errors++;
            $display("FAIL basic_row0 got %h required 00000001000000020000000300000004", wr_q.size() ? wr_q[0].d : '0);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h4E) begin
            errors++;
            $display("FAIL basic_checksum got %h required 0000004e", checksum);
        end
`endif
    endtask

    task automatic test_gap();
        logic [DW-1:0] w[NW];
        for (int i = 0; i < NW; i++) w[i] = 32'(i + 1);
        clear_mon();
        pulse_start();
        for (int i = 0; i < NW; i++) send(w[i], 1'b1);
        check_load("toggle", w, 1'b0);
    endtask

    task automatic test_restart();
        logic [DW-1:0] w[NW];
        rand_words(w);
        run_load(w, 1'b0, 1'b1);
        check_load("restart", w, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[NW];
        rand_words(w);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 6; i++) send(w[i], 1'b0);
        bus.s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid");
        checks++;
        if (wr_q.size() != 1) begin
            errors++;
            $display("FAIL reset_mid writes got %0d required 1", wr_q.size());
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        rand_words(w);
        run_load(w, 1'b0, 1'b0);
        check_load("reload", w, 1'b1);
    endtask

    task automatic test_idle();
        clear_mon();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_data = $urandom;
            @(negedge clk);
            checks++;
            if (bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready cycle%0d got %b required 0", i, bus.s_ready);
            end
            tick();
        end
        bus.s_valid = 1'b0;
        checks++;
        if (acc_q.size() != 0 || wr_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_activity accepts=%0d writes=%0d busy=%b required 0 0 0", acc_q.size(), wr_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w[NW];
        for (int k = 0; k < 4; k++) begin
            rand_words(w);
            run_load(w, 1'(k & 1), 1'b0);
            check_load("random", w, !(k & 1));
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_basic();
        test_gap();
        test_restart();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
